// File: rtl/coeff_bridge.sv
// coeff_bridge: sweeps W taps out to the W0 LUT-FIR as 2-bit codes from a 2nd-order
// error-feedback 4-level quantiser. Define COEFF_BRIDGE_INTERP_EN for linear interpolation.
module coeff_bridge #(
  parameter int W_N     = 32,
  parameter int RATIO   = 32,
  parameter int COEFF_W = 16
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             start_in,
  input  logic                             auto_restart_in,
  output logic [$clog2(W_N)-1:0]           coeff_rd_idx,
  input  logic signed [COEFF_W-1:0]        coeff_rd_data,
  output logic                             upd_valid_out,
  output logic [$clog2(W_N*RATIO)-1:0]     upd_idx_out,
  output logic [1:0]                       upd_code_out,
  output logic                             busy_out,
  output logic                             done_out
);

  localparam int IW    = $clog2(W_N);
  localparam int PW    = $clog2(W_N*RATIO);
  localparam int LOG2R = $clog2(RATIO);
  localparam int QW    = COEFF_W + 3;

  localparam logic [PW-1:0]        LAST_P    = PW'(W_N*RATIO-1);
  localparam logic [PW:0]          LAST_TAP  = (PW+1)'(W_N-1);
  localparam logic signed [QW-1:0] STEP      = {5'b00000, 1'b1, {(COEFF_W-3){1'b0}}};
  localparam logic signed [QW-1:0] TWO_S     = STEP <<< 1;
  localparam logic signed [QW-1:0] THREE_S   = STEP + TWO_S;
  localparam logic signed [QW-1:0] FOUR_S    = STEP <<< 2;
  localparam logic signed [QW-1:0] NEG_STEP  = -STEP;
  localparam logic signed [QW-1:0] NEG_TWO_S = -TWO_S;
  localparam logic signed [QW-1:0] NEG_THR_S = -THREE_S;
  localparam logic signed [QW-1:0] NEG_FOUR_S = -FOUR_S;

  typedef enum logic [1:0] {IDLE, PRIME, SWEEP, DONE} state_t;

  state_t                  r_state;
  logic                    r_start;
  logic                    r_pend;
  logic [PW-1:0]           r_p;
  logic [IW-1:0]           r_rdIdx;
  logic signed [QW-1:0]    r_e1;
  logic signed [QW-1:0]    r_e2;
  logic                    r_updValid;
  logic [PW-1:0]           r_updIdx;
  logic [1:0]              r_updCode;
  logic                    r_busy;
  logic                    r_done;

  logic signed [COEFF_W-1:0] w_x;
  logic signed [QW-1:0]      w_v;
  logic signed [QW-1:0]      w_qs;
  logic signed [QW-1:0]      w_err;
  logic signed [QW-1:0]      w_eSat;
  logic [1:0]                w_code;

  // Source tap for position p; the index is clamped so the tail never wraps to tap 0.
  function automatic logic [IW-1:0] tapIndex(input logic [PW-1:0] p);
    logic [PW:0] k;
`ifdef COEFF_BRIDGE_INTERP_EN
    k = ({1'b0, p} >> LOG2R) + (PW+1)'(1);
`else
    k = ({1'b0, p} + (PW+1)'(RATIO/2)) >> LOG2R;
`endif
    if (k > LAST_TAP) return IW'(W_N-1);
    return k[IW-1:0];
  endfunction

`ifdef COEFF_BRIDGE_INTERP_EN
  logic signed [COEFF_W-1:0]       r_cur;
  logic [LOG2R-1:0]                w_j;
  logic signed [COEFF_W:0]         w_diff;
  logic signed [COEFF_W:0]         w_frac;
  logic signed [COEFF_W:0]         w_sum;
  logic signed [COEFF_W+LOG2R+1:0] w_prod;

  always_comb begin
    w_j    = r_p[LOG2R-1:0];
    w_diff = {coeff_rd_data[COEFF_W-1], coeff_rd_data} - {r_cur[COEFF_W-1], r_cur};
    w_prod = (COEFF_W+LOG2R+2)'(w_diff) * (COEFF_W+LOG2R+2)'($signed({1'b0, w_j}));
    w_frac = w_prod[COEFF_W+LOG2R:LOG2R];
    w_sum  = {r_cur[COEFF_W-1], r_cur} + w_frac;
    if (w_sum[COEFF_W] != w_sum[COEFF_W-1])
      w_x = w_sum[COEFF_W] ? {1'b1, {(COEFF_W-1){1'b0}}} : {1'b0, {(COEFF_W-1){1'b1}}};
    else
      w_x = w_sum[COEFF_W-1:0];
  end
`else
  always_comb begin
    w_x = coeff_rd_data;
  end
`endif

  // Error feedback pushes the quantisation noise towards high frequency.
  always_comb begin
    w_v = {{3{w_x[COEFF_W-1]}}, w_x} - (r_e1 <<< 1) + r_e2;
    if (w_v >= TWO_S) begin
      w_qs   = THREE_S;
      w_code = 2'b01;
    end else if (!w_v[QW-1]) begin
      w_qs   = STEP;
      w_code = 2'b11;
    end else if (w_v >= NEG_TWO_S) begin
      w_qs   = NEG_STEP;
      w_code = 2'b10;
    end else begin
      w_qs   = NEG_THR_S;
      w_code = 2'b00;
    end
    w_err = w_qs - w_v;
    if (w_err > FOUR_S)
      w_eSat = FOUR_S;
    else if (w_err < NEG_FOUR_S)
      w_eSat = NEG_FOUR_S;
    else
      w_eSat = w_err;
  end

  // r_rdIdx is loaded one cycle ahead so the tap for p is on the read port during p.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_start    <= 1'b0;
      r_pend     <= 1'b0;
      r_p        <= '0;
      r_rdIdx    <= '0;
      r_e1       <= '0;
      r_e2       <= '0;
      r_updValid <= 1'b0;
      r_updIdx   <= '0;
      r_updCode  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef COEFF_BRIDGE_INTERP_EN
      r_cur      <= '0;
`endif
    end else begin
      r_start    <= start_in;
      r_updValid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          r_rdIdx <= '0;
          if (r_start) begin
            r_state <= PRIME;
            r_busy  <= 1'b1;
          end
        end
        PRIME: begin
          r_p     <= '0;
          r_rdIdx <= tapIndex('0);
`ifdef COEFF_BRIDGE_INTERP_EN
          r_cur   <= coeff_rd_data;
`endif
          r_state <= SWEEP;
          if (r_start) r_pend <= 1'b1;
        end
        SWEEP: begin
          r_updValid <= 1'b1;
          r_updIdx   <= r_p;
          r_updCode  <= w_code;
          r_e1       <= w_eSat;
          r_e2       <= r_e1;
`ifdef COEFF_BRIDGE_INTERP_EN
          if (&w_j) r_cur <= coeff_rd_data;
`endif
          if (r_start) r_pend <= 1'b1;
          if (r_p == LAST_P) begin
            r_state <= DONE;
            r_rdIdx <= '0;
          end else begin
            r_p     <= r_p + PW'(1);
            r_rdIdx <= tapIndex(r_p + PW'(1));
          end
        end
        DONE: begin
          r_done <= 1'b1;
          if (auto_restart_in || r_pend || r_start) begin
            r_state <= PRIME;
            r_pend  <= 1'b0;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign coeff_rd_idx  = r_rdIdx;
  assign upd_valid_out = r_updValid;
  assign upd_idx_out   = r_updIdx;
  assign upd_code_out  = r_updCode;
  assign busy_out      = r_busy;
  assign done_out      = r_done;

endmodule
